// File: rtl/fsm_input_conditioner.sv
// Input conditioner for the 2-bit Mealy controller.
// The raw {X1,X2} pair is synchronised, then debounced as one vector.
// The result is a stable x_out with a one-cycle x_valid strobe, plus a
// saturating count of rejected glitches.
module fsm_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] x_raw,
  input  logic       enable,
  output logic [1:0] x_out,
  output logic       x_valid,
  output logic [7:0] glitch_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q [SYNC_STAGES];
  logic [1:0]       x_sync;

  state_t           state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic [7:0]       glitch_q, glitch_d;

  // Synchroniser chain on both bits; it runs regardless of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= x_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign x_sync = sync_q[SYNC_STAGES-1];

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      glitch_q  <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      glitch_q  <= glitch_d;
    end
  end

  // Next-state logic. x_out is written only from the accepted candidate, so
  // it can only change as a whole qualified vector.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    x_out_d   = x_out_q;
    x_valid_d = 1'b0;
    glitch_d  = glitch_q;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (x_sync != x_out_q) begin
            cand_d  = x_sync;
            cnt_d   = CNT_W'(1);
            state_d = QUALIFY;
          end
        end
        QUALIFY: begin
          if (x_sync == cand_q && cnt_q == CNT_LAST) begin
            x_out_d   = cand_q;
            x_valid_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else if (x_sync == cand_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (x_sync == x_out_q) begin
            if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            // A third value restarts qualification without counting a glitch.
            cand_d = x_sync;
            cnt_d  = CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign x_out      = x_out_q;
  assign x_valid    = x_valid_q;
  assign glitch_cnt = glitch_q;

endmodule
